// File: rtl/in_service_control_if.sv
// Bus bundle between the 8259A in-service control block and its neighbours:
// resolver request, INTA/OCW2 commands in; INT, ISR feedback and vector out.
interface in_service_control_if;
    logic [7:0] interrupt;
    logic       inta;
    logic       aeoi_mode;
    logic       rotate_in_aeoi;
    logic [4:0] vector_base;
    logic       eoi_nonspecific;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic       set_priority;
    logic [2:0] cmd_level;
    logic       int_out;
    logic [7:0] clear_irr;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [2:0] priority_rotate;
    logic [7:0] data_out;
    logic       data_out_en;

    modport master (
        output interrupt, inta, aeoi_mode, rotate_in_aeoi, vector_base,
               eoi_nonspecific, eoi_specific, eoi_rotate, set_priority, cmd_level,
        input  int_out, clear_irr, in_service_register, highest_level_in_service,
               priority_rotate, data_out, data_out_en
    );

    modport slave (
        input  interrupt, inta, aeoi_mode, rotate_in_aeoi, vector_base,
               eoi_nonspecific, eoi_specific, eoi_rotate, set_priority, cmd_level,
        output int_out, clear_irr, in_service_register, highest_level_in_service,
               priority_rotate, data_out, data_out_en
    );
endinterface

// File: rtl/in_service_control.sv
// 8259A in-service control: INT/INTA acknowledge sequence, ISR, rotation pointer
// and EOI handling downstream of the priority resolver.
module in_service_control #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7,
    parameter logic [2:0] ROTATE_RESET   = 3'd7
) (
    input  logic                 clk,
    input  logic                 reset,
    in_service_control_if.slave  bus
);
    localparam int unsigned LEVELS = 8;
    localparam int unsigned LVL_W  = 3;

    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

    state_t             state, state_next;
    logic               int_q, int_n;
    logic [LEVELS-1:0]  clr_q, clr_n;
    logic [LEVELS-1:0]  isr_q, isr_n;
    logic [7:0]         dout_q, dout_n;
    logic               den_q, den_n;
    logic [LVL_W-1:0]   rot_q, rot_n;
    logic [LVL_W-1:0]   lvl_q, lvl_n;
    logic               spur_q, spur_n;

    logic [LEVELS-1:0]  hl;
    logic [LVL_W-1:0]   hl_lvl;
    logic [LVL_W-1:0]   scan_idx;
    logic               found;
    logic [LVL_W-1:0]   enc;
    logic [LEVELS-1:0]  clr_mask;
    logic [LEVELS-1:0]  set_mask;

    // Highest in-service level: first set ISR bit scanning up from rotate+1, wrapping.
    always_comb begin
        hl       = '0;
        hl_lvl   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < int'(LEVELS); i++) begin
            scan_idx = LVL_W'(rot_q + LVL_W'(i) + LVL_W'(1));
            if (!found && isr_q[scan_idx]) begin
                found        = 1'b1;
                hl[scan_idx] = 1'b1;
                hl_lvl       = scan_idx;
            end
        end
    end

    // Binary encode of the resolver's one-hot winner.
    always_comb begin
        enc = '0;
        for (int i = int'(LEVELS) - 1; i >= 0; i--) begin
            if (bus.interrupt[i]) enc = LVL_W'(i);
        end
    end

    always_comb begin
        state_next = state;
        int_n      = int_q;
        clr_n      = '0;
        den_n      = 1'b0;
        dout_n     = dout_q;
        lvl_n      = lvl_q;
        spur_n     = spur_q;
        rot_n      = rot_q;
        clr_mask   = '0;
        set_mask   = '0;

        if (bus.eoi_specific) begin
            clr_mask = LEVELS'(1) << bus.cmd_level;
            if (bus.eoi_rotate) rot_n = bus.cmd_level;
        end else if (bus.eoi_nonspecific && found) begin
            clr_mask = hl;
            if (bus.eoi_rotate) rot_n = hl_lvl;
        end

        case (state)
            IDLE: begin
                if (int_q && bus.inta) begin
                    state_next = ACK1;
                    int_n      = 1'b0;
                    if (bus.interrupt != '0) begin
                        lvl_n    = enc;
                        spur_n   = 1'b0;
                        set_mask = LEVELS'(1) << enc;
                        clr_n    = LEVELS'(1) << enc;
                    end else begin
                        lvl_n  = SPURIOUS_LEVEL;
                        spur_n = 1'b1;
                    end
                end else if (!int_q && bus.interrupt != '0) begin
                    int_n = 1'b1;
                end
            end
            ACK1: begin
                if (bus.inta) begin
                    state_next = ACK2;
                    dout_n     = {bus.vector_base, lvl_q};
                    den_n      = 1'b1;
                    // A spurious acknowledge never set an ISR bit, so AEOI has nothing to retire.
                    if (bus.aeoi_mode && !spur_q) begin
                        clr_mask = clr_mask | (LEVELS'(1) << lvl_q);
                        if (bus.rotate_in_aeoi) rot_n = lvl_q;
                    end
                end
            end
            ACK2:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (bus.set_priority) rot_n = bus.cmd_level;

        isr_n = (isr_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            int_q  <= 1'b0;
            clr_q  <= '0;
            isr_q  <= '0;
            dout_q <= '0;
            den_q  <= 1'b0;
            rot_q  <= ROTATE_RESET;
            lvl_q  <= '0;
            spur_q <= 1'b0;
        end else begin
            state  <= state_next;
            int_q  <= int_n;
            clr_q  <= clr_n;
            isr_q  <= isr_n;
            dout_q <= dout_n;
            den_q  <= den_n;
            rot_q  <= rot_n;
            lvl_q  <= lvl_n;
            spur_q <= spur_n;
        end
    end

    assign bus.int_out                  = int_q;
    assign bus.clear_irr                = clr_q;
    assign bus.in_service_register      = isr_q;
    assign bus.highest_level_in_service = hl;
    assign bus.priority_rotate          = rot_q;
    assign bus.data_out                 = dout_q;
    assign bus.data_out_en              = den_q;
endmodule

// File: tb/tb_in_service_control.sv
// Directed vector bench for in_service_control: one table row per clock cycle,
// followed by a hand-written asynchronous reset in the middle of an acknowledge.
module tb_in_service_control;
    logic clk;
    logic reset;

    in_service_control_if bus();

    in_service_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] intr;
        logic       inta;
        logic       aeoi;
        logic       raeoi;
        logic       ns;
        logic       sp;
        logic       erot;
        logic       setp;
        logic [2:0] lvl;
        logic       e_int;
        logic [7:0] e_clr;
        logic [7:0] e_isr;
        logic [7:0] e_hl;
        logic [2:0] e_rot;
        logic [7:0] e_dout;
        logic       e_den;
    } vec_t;

    vec_t tbl[$];
    int   vectors;
    int   miscompares;

    task automatic add(input logic [7:0] intr, input logic inta, input logic aeoi,
                       input logic raeoi, input logic ns, input logic sp, input logic erot,
                       input logic setp, input logic [2:0] lvl, input logic e_int,
                       input logic [7:0] e_clr, input logic [7:0] e_isr, input logic [7:0] e_hl,
                       input logic [2:0] e_rot, input logic [7:0] e_dout, input logic e_den);
        vec_t v;
        v.intr = intr; v.inta = inta; v.aeoi = aeoi; v.raeoi = raeoi;
        v.ns = ns; v.sp = sp; v.erot = erot; v.setp = setp; v.lvl = lvl;
        v.e_int = e_int; v.e_clr = e_clr; v.e_isr = e_isr; v.e_hl = e_hl;
        v.e_rot = e_rot; v.e_dout = e_dout; v.e_den = e_den;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [7:0] act,
                       input logic [7:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input logic e_int, input logic [7:0] e_clr,
                           input logic [7:0] e_isr, input logic [7:0] e_hl,
                           input logic [2:0] e_rot, input logic [7:0] e_dout,
                           input logic e_den);
        chk("int_out",   row, 8'(bus.int_out), 8'(e_int));
        chk("clear_irr", row, bus.clear_irr, e_clr);
        chk("isr",       row, bus.in_service_register, e_isr);
        chk("hlis",      row, bus.highest_level_in_service, e_hl);
        chk("rotate",    row, 8'(bus.priority_rotate), 8'(e_rot));
        chk("data_out",  row, bus.data_out, e_dout);
        chk("data_en",   row, 8'(bus.data_out_en), 8'(e_den));
    endtask

    task automatic idle_inputs();
        bus.interrupt       = '0;
        bus.inta            = 1'b0;
        bus.aeoi_mode       = 1'b0;
        bus.rotate_in_aeoi  = 1'b0;
        bus.eoi_nonspecific = 1'b0;
        bus.eoi_specific    = 1'b0;
        bus.eoi_rotate      = 1'b0;
        bus.set_priority    = 1'b0;
        bus.cmd_level       = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.vector_base = 5'b01000;
        idle_inputs();
        reset = 1'b1;

        //   intr  ia ae ra ns sp er st lvl | int clr  isr  hl   rot  dout den
        // Basic acknowledge of IR3, vector 0x43, then plain EOI.
        add(8'h08, 1, 0, 0, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 8'h00, 7, 8'h00, 0);
        add(8'h08, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h08, 8'h08, 8'h08, 7, 8'h00, 0);
        add(8'h00, 0, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h08, 8'h08, 7, 8'h00, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h08, 8'h08, 7, 8'h43, 1);
        add(8'h00, 0, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h08, 8'h08, 7, 8'h43, 0);
        add(8'h00, 0, 0, 0, 1, 0, 0, 0, 0,  0, 8'h00, 8'h00, 8'h00, 7, 8'h43, 0);
        // AEOI with rotation on IR2.
        add(8'h04, 0, 1, 1, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 8'h00, 7, 8'h43, 0);
        add(8'h04, 1, 1, 1, 0, 0, 0, 0, 0,  0, 8'h04, 8'h04, 8'h04, 7, 8'h43, 0);
        add(8'h00, 1, 1, 1, 0, 0, 0, 0, 0,  0, 8'h00, 8'h00, 8'h00, 2, 8'h42, 1);
        add(8'h00, 0, 1, 1, 0, 0, 0, 0, 0,  0, 8'h00, 8'h00, 8'h00, 2, 8'h42, 0);
        // Spurious: request withdrawn before the first INTA.
        add(8'h01, 0, 0, 0, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 8'h00, 2, 8'h42, 0);
        add(8'h00, 0, 0, 0, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 8'h00, 2, 8'h42, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h00, 8'h00, 2, 8'h42, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h00, 8'h00, 2, 8'h47, 1);
        add(8'h00, 0, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h00, 8'h00, 2, 8'h47, 0);
        // Build ISR=0x82 with rotate=0, then non-specific EOI retires IR1.
        add(8'h00, 0, 0, 0, 0, 0, 0, 1, 0,  0, 8'h00, 8'h00, 8'h00, 0, 8'h47, 0);
        add(8'h02, 0, 0, 0, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 8'h00, 0, 8'h47, 0);
        add(8'h02, 1, 0, 0, 0, 0, 0, 0, 0,  0, 8'h02, 8'h02, 8'h02, 0, 8'h47, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h02, 8'h02, 0, 8'h41, 1);
        add(8'h00, 0, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h02, 8'h02, 0, 8'h41, 0);
        add(8'h80, 0, 0, 0, 0, 0, 0, 0, 0,  1, 8'h00, 8'h02, 8'h02, 0, 8'h41, 0);
        add(8'h80, 1, 0, 0, 0, 0, 0, 0, 0,  0, 8'h80, 8'h82, 8'h02, 0, 8'h41, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h82, 8'h02, 0, 8'h47, 1);
        add(8'h00, 0, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h82, 8'h02, 0, 8'h47, 0);
        add(8'h00, 0, 0, 0, 1, 0, 0, 0, 0,  0, 8'h00, 8'h80, 8'h80, 0, 8'h47, 0);
        // Specific EOI of IR3 on the same edge that sets IR3: set wins.
        add(8'h08, 0, 0, 0, 0, 0, 0, 0, 0,  1, 8'h00, 8'h80, 8'h80, 0, 8'h47, 0);
        add(8'h08, 1, 0, 0, 0, 1, 0, 0, 3,  0, 8'h08, 8'h88, 8'h08, 0, 8'h47, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h88, 8'h08, 0, 8'h43, 1);
        add(8'h00, 0, 0, 0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h88, 8'h08, 0, 8'h43, 0);
        // Set-priority beats rotating non-specific EOI; the EOI still clears IR3.
        add(8'h00, 0, 0, 0, 1, 0, 1, 1, 5,  0, 8'h00, 8'h80, 8'h80, 5, 8'h43, 0);
        // Rotating specific EOI on an already-clear bit still rotates.
        add(8'h00, 0, 0, 0, 0, 1, 1, 0, 2,  0, 8'h00, 8'h80, 8'h80, 2, 8'h43, 0);
        add(8'h00, 0, 0, 0, 0, 1, 0, 0, 7,  0, 8'h00, 8'h00, 8'h00, 2, 8'h43, 0);
        // Rotating non-specific EOI with an empty ISR does nothing.
        add(8'h00, 0, 0, 0, 1, 0, 1, 0, 0,  0, 8'h00, 8'h00, 8'h00, 2, 8'h43, 0);

        // Reset state while reset is held.
        @(negedge clk);
        @(negedge clk);
        vectors++;
        chk_all(-1, 1'b0, 8'h00, 8'h00, 8'h00, 3'd7, 8'h00, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.interrupt       = tbl[i].intr;
            bus.inta            = tbl[i].inta;
            bus.aeoi_mode       = tbl[i].aeoi;
            bus.rotate_in_aeoi  = tbl[i].raeoi;
            bus.eoi_nonspecific = tbl[i].ns;
            bus.eoi_specific    = tbl[i].sp;
            bus.eoi_rotate      = tbl[i].erot;
            bus.set_priority    = tbl[i].setp;
            bus.cmd_level       = tbl[i].lvl;
            @(negedge clk);
            vectors++;
            chk_all(i, tbl[i].e_int, tbl[i].e_clr, tbl[i].e_isr, tbl[i].e_hl,
                    tbl[i].e_rot, tbl[i].e_dout, tbl[i].e_den);
        end

        // Asynchronous reset while sitting in ACK1 with IR4 in service.
        idle_inputs();
        bus.interrupt = 8'h10;
        @(negedge clk);
        vectors++;
        chk("rst_seq int_out", 100, 8'(bus.int_out), 8'h01);
        bus.inta = 1'b1;
        @(negedge clk);
        idle_inputs();
        vectors++;
        chk("rst_seq isr", 101, bus.in_service_register, 8'h10);
        #2 reset = 1'b1;
        #1;
        vectors++;
        chk_all(102, 1'b0, 8'h00, 8'h00, 8'h00, 3'd7, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        // INTA pulses after reset must be ignored: no INT is pending.
        bus.inta = 1'b1;
        @(negedge clk);
        vectors++;
        chk_all(103, 1'b0, 8'h00, 8'h00, 8'h00, 3'd7, 8'h00, 1'b0);
        @(negedge clk);
        vectors++;
        chk_all(104, 1'b0, 8'h00, 8'h00, 8'h00, 3'd7, 8'h00, 1'b0);
        bus.inta      = 1'b0;
        bus.interrupt = 8'h01;
        @(negedge clk);
        vectors++;
        chk_all(105, 1'b1, 8'h00, 8'h00, 8'h00, 3'd7, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
